// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
// Contents:
//   state_t           transmitter FSM states
//   PAR_NONE/EVEN/ODD parity_mode encodings (2'b11 is treated as none)
//   BAUD_DIV_DEFAULT  clocks per bit for 9600 baud from a 50 MHz clock
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int BAUD_DIV_DEFAULT = 5208;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Write port of the UART transmitter.
// Signals:
//   trmt         write strobe; word accepted when trmt & tx_rdy
//   tx_data      word to send (DATA_BITS wide)
//   parity_mode  parity selection, sampled when a frame is loaded
//   tx_rdy       FIFO not full
//   tx_ovf       one-cycle pulse when a write was dropped (FIFO full)
// Modports: master = producer of words, slave = the transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 trmt;
  logic [DATA_BITS-1:0] tx_data;
  logic [1:0]           parity_mode;
  logic                 tx_rdy;
  logic                 tx_ovf;

  modport master (
    output trmt,
    output tx_data,
    output parity_mode,
    input  tx_rdy,
    input  tx_ovf
  );

  modport slave (
    input  trmt,
    input  tx_data,
    input  parity_mode,
    output tx_rdy,
    output tx_ovf
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words for the UART transmitter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, wdata write request and word (ignored when full)
//   pop, rdata  read request (ignored when empty); rdata shows the head word
//   full, empty status derived from the pointers
//   count       registered number of stored words
// Pointers carry one extra MSB so that full and empty differ only in it.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [PW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign rdata   = mem[rptr_q[AW-1:0]];
  assign count   = count_q;
  // A push into a full FIFO is refused even if a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr_q[AW-1:0]] <= wdata;
        wptr_q              <= wptr_q + PW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with programmable baud divisor, data width,
// parity and stop bits. Frames are sent LSB-first, back to back, with no
// idle gap while the FIFO holds words.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wr          write port (trmt/tx_data/parity_mode in, tx_rdy/tx_ovf out)
//   TX          serial line, idles high
//   tx_busy     frame in progress or FIFO non-empty
//   tx_done     one-cycle pulse on the last stop-bit clock of each frame
// All outputs are registered, so TX trails the FSM state by one clock; the
// start bit therefore appears two clocks after a write into an idle FIFO.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_cfg_if.slave   wr,
  output logic           TX,
  output logic           tx_busy,
  output logic           tx_done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  function automatic logic parity_of(input logic [1:0] mode,
                                     input logic [DATA_BITS-1:0] d);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q;
  logic [CW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 tx_q;
  logic                 done_q;
  logic                 busy_q;
  logic                 ovf_q;

  logic                 bit_end;
  logic                 load;
  logic                 pop;
  logic                 tx_d;
  logic                 done_d;

  logic                 push;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [PW-1:0]        fifo_count;

  assign push      = wr.trmt & ~fifo_full;
  assign wr.tx_rdy = ~fifo_full;
  assign wr.tx_ovf = ovf_q;
  assign TX        = tx_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign bit_end   = (baud_q == BAUD_LAST);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr.tx_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end && (bit_q == DATA_LAST)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_d = par_bit_q;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end && (bit_q == STOP_LAST)) begin
          done_d = 1'b1;
          // Chain straight into the next start bit when a word is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, baud and bit counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load || bit_end || (state_q == IDLE)) baud_q <= '0;
      else                                      baud_q <= baud_q + BW'(1);
      // The bit counter is reused for stop bits, so it restarts on every state change.
      if (load || (state_d != state_q))
        bit_q <= '0;
      else if (bit_end && ((state_q == DATA) || (state_q == STOP)))
        bit_q <= bit_q + CW'(1);
    end
  end

  // Frame datapath: word, parity choice and parity bit latched at load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (load) begin
      shift_q   <= fifo_rdata;
      par_en_q  <= (wr.parity_mode == PAR_EVEN) || (wr.parity_mode == PAR_ODD);
      par_bit_q <= parity_of(wr.parity_mode, fifo_rdata);
    end else if ((state_q == DATA) && bit_end) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= 1'b1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      done_q <= done_d;
      busy_q <= (state_q != IDLE) || (fifo_count != '0);
      ovf_q  <= wr.trmt & fifo_full;
    end
  end

endmodule
